sext_align_pipe: RTL and testbench

SEXT_ALIGN_PIPE -- requirements
Module: sext_align_pipe

---
 rtl/sext_align_pipe_pkg.sv | 23 ++
 rtl/sext_align_pipe_zero_run_det.sv | 36 +++
 rtl/sext_align_pipe.sv | 121 ++++++++++++
 tb/tb_sext_align_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sext_align_pipe_pkg.sv
// Shared widths, mode encodings and width-derivation helpers for the sign-extend/align pipeline.
// Pure compile-time content: no latency, no flow control.
package sext_align_pipe_pkg;

    localparam int DEF_IN_W     = 16;
    localparam int DEF_GUARD_W  = 8;
    localparam int DEF_FRAC_W   = 16;
    localparam int DEF_NCH      = 2;
    localparam int DEF_SHIFT_W  = 4;
    localparam int DEF_ZERO_RUN = 800;

    localparam logic MODE_SIGNED   = 1'b0;
    localparam logic MODE_UNSIGNED = 1'b1;

    function automatic int calc_out_w(input int in_w, input int guard_w, input int frac_w);
        return in_w + guard_w + frac_w;
    endfunction

    function automatic int calc_ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sext_align_pipe_zero_run_det.sv
// Per-channel consecutive-zero counter; saturates at ZERO_RUN, flag lags the count by one cycle.
// Updates only on accepted samples for its channel; never stalls anything.
module zero_run_det
    import sext_align_pipe_pkg::*;
#(
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    localparam int CNT_W   = $clog2(ZERO_RUN + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    input  logic is_zero,
    output logic flag
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(ZERO_RUN);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            flag <= (cnt == RUN_MAX);
            if (hit) begin
                if (!is_zero) begin
                    cnt <= '0;
                end else if (cnt != RUN_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sext_align_pipe.sv
// Two-stage sign/zero-extend, fraction-pad and right-shift pipeline with per-channel zero-run flags.
// Latency 2, 1 sample/cycle; valid/ready backpressure propagates combinationally to in_ready.
module sext_align_pipe
    import sext_align_pipe_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int GUARD_W  = DEF_GUARD_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int NCH      = DEF_NCH,
    parameter int SHIFT_W  = DEF_SHIFT_W,
    parameter int ZERO_RUN = DEF_ZERO_RUN,
    localparam int OUT_W   = calc_out_w(IN_W, GUARD_W, FRAC_W),
    localparam int CH_W    = calc_ch_w(NCH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic [NCH-1:0]     zero_flag
);

    logic               s1_valid;
    logic [OUT_W-1:0]   s1_ext;
    logic [CH_W-1:0]    s1_ch;
    logic [SHIFT_W-1:0] s1_shift;
    logic               s1_mode;

    logic               s2_valid;
    logic [OUT_W-1:0]   s2_data;
    logic [CH_W-1:0]    s2_ch;

    logic s2_adv;
    logic s1_load;
    logic in_xfer;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_adv;
    assign in_ready = s1_load;
    assign in_xfer  = in_valid && in_ready;

    logic [GUARD_W-1:0] guard;
    logic [OUT_W-1:0]   ext_in;

    assign guard  = (in_mode == MODE_SIGNED) ? {GUARD_W{in_data[IN_W-1]}} : '0;
    assign ext_in = {guard, in_data, {FRAC_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ext   <= '0;
            s1_ch    <= '0;
            s1_shift <= '0;
            s1_mode  <= MODE_SIGNED;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ext   <= ext_in;
                s1_ch    <= in_ch;
                s1_shift <= in_shift;
                s1_mode  <= in_mode;
            end
        end
    end

    // Kept as separate signed/unsigned nets so the arithmetic shift is not demoted by mixed-sign context.
    logic signed [OUT_W-1:0] ext_signed;
    logic signed [OUT_W-1:0] arith_sh;
    logic        [OUT_W-1:0] logic_sh;
    logic        [OUT_W-1:0] shifted;

    assign ext_signed = s1_ext;
    assign arith_sh   = ext_signed >>> s1_shift;
    assign logic_sh   = s1_ext >> s1_shift;
    assign shifted    = (s1_mode == MODE_SIGNED) ? arith_sh : logic_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ch    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= shifted;
                s2_ch   <= s1_ch;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_ch    = s2_ch;

    logic in_is_zero;
    assign in_is_zero = (in_data == '0);

    // Channel tags >= NCH match no detector, so they never touch any counter.
    for (genvar c = 0; c < NCH; c++) begin : g_zdet
        logic hit;
        assign hit = in_xfer && (in_ch == CH_W'(c));

        zero_run_det #(
            .ZERO_RUN(ZERO_RUN)
        ) u_zdet (
            .clk    (clk),
            .reset  (reset),
            .hit    (hit),
            .is_zero(in_is_zero),
            .flag   (zero_flag[c])
        );
    end

endmodule

// File: tb/tb_sext_align_pipe.sv
// Self-checking bench: scoreboard of arithmetically derived results plus a per-channel zero-run model.
module tb_sext_align_pipe;

    localparam int NCH = 2;
    localparam int ZR  = 800;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [0:0]  in_ch;
    logic [3:0]  in_shift;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic [0:0]  out_ch;
    logic [1:0]  zero_flag;

    sext_align_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ch    (in_ch),
        .in_shift (in_shift),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] d;
        logic [0:0]  ch;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          zcnt[NCH];
    logic [1:0]  exp_flag = 2'b00;
    bit          rand_ready = 0;
    bit          stall_prev = 0;
    logic [39:0] stall_d;
    logic [0:0]  stall_ch;
    int          n_out = 0;

    logic [15:0] vd[7] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    logic        vm[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  vs[7] = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd15, 4'd15};
    logic [39:0] vx[7] = '{40'hFF80000000, 40'h007FFF0000, 40'h0080000000, 40'hFFF8000000,
                           40'h0008000000, 40'hFFFFFF0000, 40'h000001FFFE};

    // Value of the sample as an integer, scaled by 2^FRAC_W, then floor-divided by 2^shift.
    function automatic logic [39:0] exp_result(input logic [15:0] d, input logic m, input logic [3:0] sh);
        longint v;
        v = longint'(d);
        if (m == 1'b0 && d[15]) v = v - 65536;
        v = v * 65536;
        v = v >>> sh;
        return v[39:0];
    endfunction

    task automatic cycle(output bit acc_in);
        bit   acc_out;
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        acc_in  = in_valid && in_ready && !reset;
        acc_out = out_valid && out_ready && !reset;
        if (stall_prev && !reset) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== stall_d || out_ch !== stall_ch) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b data=%h ch=%h, required valid=1 data=%h ch=%h",
                         out_valid, out_data, out_ch, stall_d, stall_ch);
            end
        end
        stall_prev = out_valid && !out_ready && !reset;
        stall_d    = out_data;
        stall_ch   = out_ch;
        if (acc_out) begin
            n_tests++;
            n_out++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL out_extra: got data=%h ch=%h, required no output", out_data, out_ch);
            end else begin
                e = q.pop_front();
                if (out_data !== e.d || out_ch !== e.ch) begin
                    n_fail++;
                    $display("FAIL out_data: got data=%h ch=%h, required data=%h ch=%h",
                             out_data, out_ch, e.d, e.ch);
                end
            end
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            for (int c = 0; c < NCH; c++) zcnt[c] = 0;
            exp_flag   = 2'b00;
            stall_prev = 0;
        end else begin
            for (int c = 0; c < NCH; c++) exp_flag[c] = (zcnt[c] == ZR);
            if (acc_in) begin
                q.push_back('{d: exp_result(in_data, in_mode, in_shift), ch: in_ch});
                if (in_data == 16'h0) begin
                    if (zcnt[int'(in_ch)] < ZR) zcnt[int'(in_ch)]++;
                end else begin
                    zcnt[int'(in_ch)] = 0;
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (zero_flag !== exp_flag) begin
            n_fail++;
            $display("FAIL zero_flag_model: got %b, required %b", zero_flag, exp_flag);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [0:0] ch, input logic m, input logic [3:0] sh);
        bit acc;
        in_data  = d;
        in_ch    = ch;
        in_mode  = m;
        in_shift = sh;
        in_valid = 1'b1;
        acc      = 0;
        for (int k = 0; k < 100 && !acc; k++) cycle(acc);
        in_valid = 1'b0;
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: got no acceptance of %h in 100 cycles, required acceptance", d);
        end
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < 300 && q.size() > 0; k++) cycle(acc);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs still pending, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        bit acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle(acc);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 40'h0 || out_ch !== 1'b0 || zero_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h ch=%b flag=%b, required all zero",
                     out_valid, out_data, out_ch, zero_flag);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        bit acc;
        rand_ready = 0;
        out_ready  = 1'b1;
        drain();
        for (int i = 0; i < 7; i++) begin
            send(vd[i], 1'b0, vm[i], vs[i]);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_early[%0d]: got out_valid=%b after 1 cycle, required 0", i, out_valid);
            end
            cycle(acc);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== vx[i]) begin
                n_fail++;
                $display("FAIL vector[%0d]: got valid=%b data=%h, required valid=1 data=%h",
                         i, out_valid, out_data, vx[i]);
            end
            cycle(acc);
        end
    endtask

    task automatic test_stream();
        bit acc;
        rand_ready = 1;
        n_out      = 0;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i), 1'($urandom_range(0, 1)), 1'b0, 4'd0);
            if ($urandom_range(0, 3) == 0) cycle(acc);
        end
        drain();
        n_tests++;
        if (n_out != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs, required 16", n_out);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        drain();
    endtask

    task automatic test_zero_run();
        bit acc;
        rand_ready = 0;
        out_ready  = 1'b1;
        send(16'h0001, 1'b0, 1'b0, 4'd0);
        send(16'h0001, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < ZR; i++) begin
            if (i == ZR - 1) begin
                n_tests++;
                if (zero_flag !== 2'b00) begin
                    n_fail++;
                    $display("FAIL zero_run_early: got %b before last zero, required 00", zero_flag);
                end
            end
            send(16'h0000, 1'b0, 1'b0, 4'd0);
            send(16'($urandom) | 16'h0001, 1'b1, 1'b0, 4'd0);
        end
        n_tests++;
        if (zero_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_run_set: got %b, required 01", zero_flag);
        end
        send(16'h0001, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (zero_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_run_hold: got %b on accept cycle, required 01", zero_flag);
        end
        cycle(acc);
        n_tests++;
        if (zero_flag !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_run_clear: got %b, required 00", zero_flag);
        end
        for (int i = 0; i < ZR; i++) send(16'h0000, 1'b0, 1'b0, 4'd0);
        cycle(acc);
        n_tests++;
        if (zero_flag !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_run_refill: got %b, required 01", zero_flag);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        bit acc;
        rand_ready = 0;
        out_ready  = 1'b0;
        send(16'h1234, 1'b0, 1'b0, 4'd0);
        send(16'h5678, 1'b1, 1'b1, 4'd2);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pipe: got in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
        end
        in_data   = 16'h0000;
        in_ch     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b1;
        cycle(acc);
        n_tests++;
        if (out_valid !== 1'b0 || zero_flag !== 2'b00 || out_data !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_midflight: got valid=%b flag=%b data=%h, required 0/00/0",
                     out_valid, zero_flag, out_data);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
        send(16'h00A5, 1'b1, 1'b0, 4'd1);
        drain();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ch     = '0;
        in_shift  = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < NCH; c++) zcnt[c] = 0;
        test_reset();
        test_vectors();
        test_stream();
        test_random();
        test_zero_run();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
